// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and iteration count for the EX-stage multiply/divide unit.
package muldiv_pkg;
    localparam logic [3:0] OP_MULT  = 4'hA;
    localparam logic [3:0] OP_MULTU = 4'hB;
    localparam logic [3:0] OP_DIV   = 4'hC;
    localparam logic [3:0] OP_DIVU  = 4'hD;

    localparam int ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_DIV   = 2'd2,
        S_FIXUP = 2'd3
    } state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Two's-complement helpers: operand magnitudes at accept, and sign restoration of the
// product or quotient/remainder when HI/LO are written.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    input  logic           i_signed,
    output logic [W-1:0]   o_mag_a,
    output logic [W-1:0]   o_mag_b,
    output logic           o_neg_a,
    output logic           o_neg_b,
    input  logic [2*W-1:0] i_acc,
    input  logic           i_is_mul,
    input  logic           i_neg_main,
    input  logic           i_neg_rem,
    output logic [W-1:0]   o_hi,
    output logic [W-1:0]   o_lo
);
    logic [2*W-1:0] w_prod;

    assign o_neg_a = i_signed & i_a[W-1];
    assign o_neg_b = i_signed & i_b[W-1];
    assign o_mag_a = o_neg_a ? -i_a : i_a;
    assign o_mag_b = o_neg_b ? -i_b : i_b;
    assign w_prod  = i_neg_main ? -i_acc : i_acc;

    always_comb begin
        if (i_is_mul) begin
            {o_hi, o_lo} = w_prod;
        end else begin
            o_hi = i_neg_rem  ? -i_acc[2*W-1:W] : i_acc[2*W-1:W];
            o_lo = i_neg_main ? -i_acc[W-1:0]   : i_acc[W-1:0];
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider writing HI/LO.
// Divide support is built only when MULDIV_DIV_EN is defined.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int NrOfBits  = 32,
    parameter int AluOpBits = 4
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 Valid,
    input  logic [AluOpBits-1:0] AluOp,
    input  logic [NrOfBits-1:0]  SrcA,
    input  logic [NrOfBits-1:0]  SrcB,
    input  logic                 Flush,
    output logic                 Busy,
    output logic                 Done,
    output logic [NrOfBits-1:0]  Hi,
    output logic [NrOfBits-1:0]  Lo,
    output logic                 DivByZero
);
    localparam int W = NrOfBits;

    state_t           r_state;
    logic [5:0]       r_cnt;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_opnd;
    logic             r_is_mul, r_neg_main, r_neg_rem, r_done;
    logic [W-1:0]     r_hi, r_lo;

    logic             w_adv, w_is_mul, w_is_div, w_signed, w_b_zero;
    logic [W-1:0]     w_mag_a, w_mag_b, w_hi, w_lo;
    logic             w_neg_a, w_neg_b;
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_next;

    assign w_adv    = ClockEnable & Tick;
    assign w_is_mul = (AluOp == AluOpBits'(OP_MULT)) | (AluOp == AluOpBits'(OP_MULTU));
    assign w_signed = (AluOp == AluOpBits'(OP_MULT)) | (AluOp == AluOpBits'(OP_DIV));
    assign w_b_zero = (SrcB == '0);

    muldiv_sign_fix #(.W(W)) u_sign_fix (
        .i_a       (SrcA),
        .i_b       (SrcB),
        .i_signed  (w_signed),
        .o_mag_a   (w_mag_a),
        .o_mag_b   (w_mag_b),
        .o_neg_a   (w_neg_a),
        .o_neg_b   (w_neg_b),
        .i_acc     (r_acc),
        .i_is_mul  (r_is_mul),
        .i_neg_main(r_neg_main),
        .i_neg_rem (r_neg_rem),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    // Multiplier sits in the low half and shifts out LSB-first while partial sums enter the top.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

`ifdef MULDIV_DIV_EN
    logic       r_dbz;
    logic [W:0] w_rem_sh, w_diff;
    logic [2*W-1:0] w_div_next;

    assign w_is_div   = (AluOp == AluOpBits'(OP_DIV)) | (AluOp == AluOpBits'(OP_DIVU));
    // Remainder in the high half, dividend shifting out of the low half as quotient bits shift in.
    assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_opnd};
    assign w_div_next = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                                  : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};
    assign DivByZero  = r_dbz;
`else
    assign w_is_div   = 1'b0;
    assign DivByZero  = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_mul   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
`ifdef MULDIV_DIV_EN
            r_dbz      <= 1'b0;
`endif
        end else if (w_adv) begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Valid && (w_is_mul || w_is_div)) begin
                        r_cnt    <= '0;
                        r_is_mul <= w_is_mul;
`ifdef MULDIV_DIV_EN
                        r_dbz    <= w_is_div & w_b_zero;
`endif
                        if (w_is_mul) begin
                            r_acc      <= {{W{1'b0}}, w_mag_b};
                            r_opnd     <= w_mag_a;
                            r_neg_main <= w_neg_a ^ w_neg_b;
                            r_neg_rem  <= 1'b0;
                            r_state    <= S_MUL;
`ifdef MULDIV_DIV_EN
                        end else if (w_b_zero) begin
                            r_acc      <= {SrcA, {W{1'b1}}};
                            r_neg_main <= 1'b0;
                            r_neg_rem  <= 1'b0;
                            r_state    <= S_FIXUP;
                        end else begin
                            r_acc      <= {{W{1'b0}}, w_mag_a};
                            r_opnd     <= w_mag_b;
                            r_neg_main <= w_neg_a ^ w_neg_b;
                            r_neg_rem  <= w_neg_a;
                            r_state    <= S_DIV;
`endif
                        end
                    end
                end
                S_MUL: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_mul_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(ITERS-1)) r_state <= S_FIXUP;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt == 6'(ITERS-1)) r_state <= S_FIXUP;
                    end
                end
`endif
                S_FIXUP: begin
                    if (!Flush) begin
                        r_hi   <= w_hi;
                        r_lo   <= w_lo;
                        r_done <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Busy = (r_state != S_IDLE);
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage of the CPU pipeline. It consumes the ALU op code and the two source operands held in the ID/EX pipeline registers. For MULT/MULTU/DIV/DIVU it runs a 32-iteration shift-add or restoring-divide sequence, holds Busy for the hazard unit to stall the pipe, and writes the architectural HI/LO registers on completion. Like the pipeline registers, it advances only on ClockEnable & Tick.

## Interface
- NrOfBits, 32, operand / HI / LO width
- AluOpBits, 4, width of the ALU op code
- Clock  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- ClockEnable  in  1  global clock enable
- Tick  in  1  clock-divider tick; advance = ClockEnable & Tick
- Valid  in  1  EX-stage instruction valid
- AluOp  in  AluOpBits  op code from the EX ALU-op pipeline register
- SrcA  in  NrOfBits  multiplicand / dividend
- SrcB  in  NrOfBits  multiplier / divisor
- Flush  in  1  synchronous abort of the in-flight operation
- Busy  out  1  operation in flight, to the hazard unit
- Done  out  1  one-advance pulse when HI/LO are written
- Hi  out  NrOfBits  HI register (product high / remainder)
- Lo  out  NrOfBits  LO register (product low / quotient)
- DivByZero  out  1  last accepted divide had SrcB == 0

## Operation
- Op codes: MULT=4'hA, MULTU=4'hB, DIV=4'hC, DIVU=4'hD. All other codes are ignored.
- FSM states:
  - IDLE: on advance, if Valid and a mul/div op is present, accept the op, latch |SrcA|, |SrcB| (signed ops) or the raw values (unsigned ops), latch the sign flags, and clear count.
    - Mul op: go to MUL.
    - Div op with SrcB==0: go to FIXUP.
    - Other div op: go to DIV.
  - MUL: one shift-add step per advance. After 32 steps, go to FIXUP.
  - DIV: one restoring-subtract step per advance. After 32 steps, go to FIXUP.
  - FIXUP: apply signs, write Hi/Lo, set Done, go to IDLE.
- Sign rules:
  - Product is negated (64-bit two's complement) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
- Overflow: -2^31 / -1 gives Lo=0x80000000, Hi=0. This falls out of unsigned 32-bit magnitude arithmetic; no special case is needed.
- Divide by zero: Lo=all ones, Hi=SrcA, DivByZero=1. DivByZero is cleared at the next accepted op.
- Busy = (state != IDLE), combinational from state.
- Valid while Busy is ignored. The hazard unit must stall.
- Flush, sampled on advance in any non-IDLE state: go to IDLE; Hi/Lo are unchanged and Done is not raised. Flush in IDLE has no effect.
- Hi/Lo change only in FIXUP.

## Timing
- Reset values: state=IDLE, Busy=0, Done=0, Hi=0, Lo=0, DivByZero=0. Reset applies immediately, including mid-operation.
- Nothing changes on edges without advance. Latency is counted in advance edges.
- Normal op: accepted at advance edge 0. Hi/Lo/Done update at advance edge 33. Busy is high from after edge 0 until after edge 33.
- Divide by zero: Hi/Lo/Done update at advance edge 1.
- Done is high for exactly one advance interval, then clears at the next advance edge.
- A new op can be accepted on the advance edge that clears Done (back-to-back ops).
- Simultaneous Flush and the final iteration: Flush wins; FIXUP is not entered.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU are supported as specified above.
- MULDIV_DIV_EN undefined:
  - DIV/DIVU are treated as unrecognised ops and are never accepted.
  - The DIV state and divider datapath are removed.
  - DivByZero is tied to 0.

## Structure
- Package muldiv_pkg holds:
  - op-code localparams
  - state enum/encoding
  - iteration count constant (32)
- One sub-module, muldiv_sign_fix: combinational two's-complement magnitude/negate helpers used at accept and in FIXUP.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, advance every cycle -> Hi=0xFFFFFFFE, Lo=0x00000001, Done at advance edge 33, Busy high 33 intervals.
- MULT -3 × 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; then DIV -7 / 2 back-to-back -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU 5 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000005, DivByZero=1, Done at advance edge 1; next MULTU 1×1 clears DivByZero.
- DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000, no hang.
- Prior Hi/Lo=0x11/0x22; Flush at iteration 10 -> IDLE next advance, Hi/Lo unchanged, Done never high. Repeat with Reset_n low at iteration 10 -> Hi/Lo=0 and Busy=0 immediately.
- Tick high every other cycle during MULTU 2×3 -> Done after 66 clocks, Lo=6, no state change on non-tick edges.
